// File: rtl/aud_cfg_writer_pkg.sv
// aud_pkg: shared widths, command record, FSM state type and register addresses
package aud_pkg;
   localparam int AUD_ADDR_W = 4;
   localparam int AUD_DATA_W = 7;
   localparam logic [AUD_ADDR_W-1:0] AUD_REG_8 = 4'd8;
   localparam logic [AUD_ADDR_W-1:0] AUD_REG_9 = 4'd9;
   typedef enum logic [1:0] {IDLE, SEND, RESP} aud_wr_state_t;
   typedef struct packed {
      logic [AUD_ADDR_W-1:0] addr;
      logic [AUD_DATA_W-1:0] data;
   } aud_cmd_t;
endpackage

// File: rtl/aud_cfg_writer_if.sv
// aud_cfg_writer_if: local command port plus the controller write channel
interface aud_cfg_writer_if;
   import aud_pkg::*;
   logic cmd_valid, cmd_ready;
   logic [AUD_ADDR_W-1:0] cmd_addr, AWADDR;
   logic [AUD_DATA_W-1:0] cmd_data, WDATA;
   logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   modport master (
      input  cmd_valid, cmd_addr, cmd_data, AWREADY, WREADY, BVALID,
      output cmd_ready, AWADDR, AWVALID, WDATA, WVALID, BREADY
   );
   modport slave (
      output cmd_valid, cmd_addr, cmd_data, AWREADY, WREADY, BVALID,
      input  cmd_ready, AWADDR, AWVALID, WDATA, WVALID, BREADY
   );
endinterface

// File: rtl/aud_cfg_writer_cmd_fifo.sv
// aud_cmd_fifo: synchronous command FIFO with wrap bit on the pointers for full/empty
module aud_cmd_fifo import aud_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  aud_cmd_t                din_i,
   output aud_cmd_t                dout_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  level_o
);
   localparam int AW = $clog2(DEPTH);
   aud_cmd_t mem_q [DEPTH];
   logic [AW:0] wr_q, rd_q;
   assign level_o = wr_q - rd_q;
   // level never exceeds DEPTH, so its top bit alone means full
   assign full_o  = level_o[AW];
   assign empty_o = level_o == '0;
   assign dout_o  = mem_q[rd_q[AW-1:0]];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i) rd_q <= rd_q + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
   end
endmodule

// File: rtl/aud_cfg_writer.sv
// aud_cfg_writer: buffers register-write commands and issues each as one AW/W/B write
module aud_cfg_writer import aud_pkg::*; #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   aud_cfg_writer_if.master        bus,
   input  logic                    clr_err,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic [7:0]              wr_done_cnt,
   output logic                    err_timeout
);
   aud_wr_state_t state_q, state_d;
   aud_cmd_t cmd_in, head;
   logic full, empty, push, pop, b_hs, aw_ok, w_ok, both, tmo_evt;
   logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic aw_done_q, aw_done_d, w_done_q, w_done_d, err_q, err_d;
   logic [AUD_ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [AUD_DATA_W-1:0] wdata_q, wdata_d;
   logic [15:0] tmo_q, tmo_d;
   logic [7:0] done_q, done_d;
   assign cmd_in = {bus.cmd_addr, bus.cmd_data};
   assign push   = bus.cmd_valid && !full;
   assign b_hs   = state_q == RESP && bus.BVALID;
   // a completing response pops the next command straight into SEND
   assign pop    = !empty && (state_q == IDLE || b_hs);
   aud_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(ACLK), .rst(ARESET), .push_i(push), .pop_i(pop), .din_i(cmd_in),
      .dout_o(head), .full_o(full), .empty_o(empty), .level_o(fifo_level)
   );
   always_comb begin
      aw_ok     = aw_done_q || (awvalid_q && bus.AWREADY);
      w_ok      = w_done_q || (wvalid_q && bus.WREADY);
      both      = state_q == SEND && aw_ok && w_ok;
      tmo_evt   = state_q == RESP && !bus.BVALID && tmo_q == 16'(TIMEOUT - 1);
      state_d   = pop ? SEND : both ? RESP : b_hs ? IDLE : state_q;
      awvalid_d = pop || (awvalid_q && !bus.AWREADY);
      wvalid_d  = pop || (wvalid_q && !bus.WREADY);
      aw_done_d = state_q == SEND && aw_ok && !both;
      w_done_d  = state_q == SEND && w_ok && !both;
      bready_d  = both || (bready_q && !b_hs);
      awaddr_d  = pop ? head.addr : awaddr_q;
      wdata_d   = pop ? head.data : wdata_q;
      tmo_d     = state_q != RESP ? '0 : tmo_q == 16'(TIMEOUT) ? tmo_q : tmo_q + 16'd1;
      done_d    = done_q + {7'd0, b_hs};
      err_d     = tmo_evt || (err_q && !clr_err);
   end
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_q     <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         tmo_q     <= '0;
         done_q    <= '0;
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         err_q     <= err_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         tmo_q     <= tmo_d;
         done_q    <= done_d;
      end
   end
   assign bus.cmd_ready = !full;
   assign bus.AWADDR    = awaddr_q;
   assign bus.AWVALID   = awvalid_q;
   assign bus.WDATA     = wdata_q;
   assign bus.WVALID    = wvalid_q;
   assign bus.BREADY    = bready_q;
   assign busy          = state_q != IDLE || !empty;
   assign wr_done_cnt   = done_q;
   assign err_timeout   = err_q;
endmodule

// File: tb/tb_aud_cfg_writer.sv
// tb_aud_cfg_writer: directed tests with a scoreboard checking issued AW/W beats in order
module tb_aud_cfg_writer;
   import aud_pkg::*;
   logic clk = 1'b0, rst = 1'b0, clr_err = 1'b0;
   logic busy, err_timeout;
   logic [2:0] fifo_level;
   logic [7:0] wr_done_cnt;
   int n_pass = 0, n_total = 0, cyc = 0, c0 = 0;
   logic [3:0] exp_aw[$];
   logic [6:0] exp_w[$];
   logic aw_hold = 1'b0, w_hold = 1'b0;
   logic [3:0] aw_prev = '0;
   logic [6:0] w_prev = '0;

   aud_cfg_writer_if bus();
   aud_cfg_writer #(.DEPTH(4), .TIMEOUT(10)) dut (
      .ACLK(clk), .ARESET(rst), .bus(bus), .clr_err(clr_err), .busy(busy),
      .fifo_level(fifo_level), .wr_done_cnt(wr_done_cnt), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic slave(input logic aw, input logic w, input logic b);
      bus.AWREADY = aw;
      bus.WREADY  = w;
      bus.BVALID  = b;
   endtask

   task automatic push(input logic [3:0] a, input logic [6:0] d);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = a;
      bus.cmd_data  = d;
      for (int i = 0; i < 1000; i++) begin
         if (bus.cmd_ready) begin
            tick();
            exp_aw.push_back(a);
            exp_w.push_back(d);
            bus.cmd_valid = 1'b0;
            return;
         end
         tick();
      end
      n_total++;
      $display("FAIL push_wait: cmd_ready got 0 for 1000 cycles, expected 1");
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int lim);
      for (int i = 0; i < lim && busy; i++) tick();
      chk(nm, busy, 0);
   endtask

   // scoreboard monitor: handshakes are judged mid-cycle, before the edge that takes them
   always @(negedge clk) begin
      if (rst) begin
         aw_hold = 1'b0;
         w_hold  = 1'b0;
      end else begin
         if (aw_hold) begin
            chk("aw_held", bus.AWVALID, 1);
            chk("aw_stable", bus.AWADDR, aw_prev);
         end
         if (w_hold) begin
            chk("w_held", bus.WVALID, 1);
            chk("w_stable", bus.WDATA, w_prev);
         end
         if (bus.AWVALID && bus.AWREADY) begin
            if (exp_aw.size() == 0) begin
               n_total++;
               $display("FAIL aw_unexpected: AWADDR %0d issued, expected no write", bus.AWADDR);
            end else chk("aw_addr", bus.AWADDR, exp_aw.pop_front());
         end
         if (bus.WVALID && bus.WREADY) begin
            if (exp_w.size() == 0) begin
               n_total++;
               $display("FAIL w_unexpected: WDATA %0d issued, expected no write", bus.WDATA);
            end else chk("w_data", bus.WDATA, exp_w.pop_front());
         end
         aw_hold = bus.AWVALID && !bus.AWREADY;
         w_hold  = bus.WVALID && !bus.WREADY;
         aw_prev = bus.AWADDR;
         w_prev  = bus.WDATA;
      end
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_data  = '0;
      slave(1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      tick(2);
      chk("rst_awvalid", bus.AWVALID, 0);
      chk("rst_wvalid", bus.WVALID, 0);
      chk("rst_bready", bus.BREADY, 0);
      chk("rst_busy", busy, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_cnt", wr_done_cnt, 0);
      chk("rst_err", err_timeout, 0);
      rst = 1'b0;
      tick();
      chk("rst_cmd_ready", bus.cmd_ready, 1);

      // single write against a zero-wait slave; BVALID held high is ignored outside RESP
      slave(1'b1, 1'b1, 1'b1);
      push(AUD_REG_8, 7'd60);
      chk("t1_c1_awvalid", bus.AWVALID, 0);
      chk("t1_c1_level", fifo_level, 1);
      chk("t1_c1_busy", busy, 1);
      chk("t1_c1_cnt", wr_done_cnt, 0);
      tick();
      chk("t1_c2_awvalid", bus.AWVALID, 1);
      chk("t1_c2_wvalid", bus.WVALID, 1);
      chk("t1_c2_awaddr", bus.AWADDR, 8);
      chk("t1_c2_wdata", bus.WDATA, 60);
      chk("t1_c2_bready", bus.BREADY, 0);
      chk("t1_c2_cnt", wr_done_cnt, 0);
      tick();
      chk("t1_c3_bready", bus.BREADY, 1);
      chk("t1_c3_awvalid", bus.AWVALID, 0);
      tick();
      chk("t1_c4_bready", bus.BREADY, 0);
      chk("t1_c4_cnt", wr_done_cnt, 1);
      chk("t1_c4_busy", busy, 0);

      // W handshake three cycles before AW
      slave(1'b0, 1'b0, 1'b0);
      push(AUD_REG_9, 7'd96);
      tick();
      chk("t2_c2_awvalid", bus.AWVALID, 1);
      chk("t2_c2_wvalid", bus.WVALID, 1);
      bus.WREADY = 1'b1;
      tick();
      bus.WREADY = 1'b0;
      chk("t2_c3_wvalid", bus.WVALID, 0);
      chk("t2_c3_awvalid", bus.AWVALID, 1);
      chk("t2_c3_bready", bus.BREADY, 0);
      tick();
      chk("t2_c4_awvalid", bus.AWVALID, 1);
      chk("t2_c4_bready", bus.BREADY, 0);
      tick();
      chk("t2_c5_bready", bus.BREADY, 0);
      bus.AWREADY = 1'b1;
      tick();
      bus.AWREADY = 1'b0;
      chk("t2_c6_bready", bus.BREADY, 1);
      chk("t2_c6_awvalid", bus.AWVALID, 0);
      bus.BVALID = 1'b1;
      tick();
      bus.BVALID = 1'b0;
      chk("t2_c7_bready", bus.BREADY, 0);
      chk("t2_c7_cnt", wr_done_cnt, 2);

      // AW handshake three cycles before W
      push(4'd4, 7'd33);
      tick();
      bus.AWREADY = 1'b1;
      tick();
      bus.AWREADY = 1'b0;
      chk("t2b_c3_awvalid", bus.AWVALID, 0);
      chk("t2b_c3_wvalid", bus.WVALID, 1);
      chk("t2b_c3_wdata", bus.WDATA, 33);
      tick(2);
      chk("t2b_c5_bready", bus.BREADY, 0);
      bus.WREADY = 1'b1;
      tick();
      bus.WREADY = 1'b0;
      chk("t2b_c6_bready", bus.BREADY, 1);
      chk("t2b_c6_wvalid", bus.WVALID, 0);
      bus.BVALID = 1'b1;
      tick();
      bus.BVALID = 1'b0;
      chk("t2b_c7_cnt", wr_done_cnt, 3);

      // FIFO full: one command in flight plus four queued
      push(AUD_REG_8, 7'd60);
      push(AUD_REG_9, 7'd96);
      push(4'd3, 7'd5);
      push(4'd12, 7'd127);
      push(4'd0, 7'd1);
      chk("t3_level", fifo_level, 4);
      chk("t3_cmd_ready", bus.cmd_ready, 0);
      tick(3);
      chk("t3_level_hold", fifo_level, 4);
      chk("t3_cmd_ready_hold", bus.cmd_ready, 0);
      chk("t3_awvalid", bus.AWVALID, 1);
      slave(1'b1, 1'b1, 1'b1);
      wait_idle("t3_idle", 100);
      chk("t3_cnt", wr_done_cnt, 8);
      chk("t3_level_end", fifo_level, 0);

      // response timeout at TIMEOUT=10; clr_err in the set cycle loses
      slave(1'b1, 1'b1, 1'b0);
      push(AUD_REG_9, 7'd7);
      tick(2);
      chk("t4_resp_bready", bus.BREADY, 1);
      tick(9);
      chk("t4_err_before", err_timeout, 0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("t4_err_set", err_timeout, 1);
      chk("t4_bready_wait", bus.BREADY, 1);
      tick(2);
      chk("t4_err_sticky", err_timeout, 1);
      chk("t4_cnt_wait", wr_done_cnt, 8);
      bus.BVALID = 1'b1;
      tick();
      bus.BVALID = 1'b0;
      chk("t4_cnt_done", wr_done_cnt, 9);
      chk("t4_bready_drop", bus.BREADY, 0);
      chk("t4_err_after_b", err_timeout, 1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("t4_err_cleared", err_timeout, 0);

      // asynchronous reset mid-SEND with two commands queued
      slave(1'b0, 1'b0, 1'b0);
      push(4'd1, 7'd11);
      push(4'd2, 7'd22);
      push(4'd5, 7'd55);
      chk("t5_level", fifo_level, 2);
      chk("t5_awvalid", bus.AWVALID, 1);
      #2 rst = 1'b1;
      #1;
      chk("t5_awvalid0", bus.AWVALID, 0);
      chk("t5_wvalid0", bus.WVALID, 0);
      chk("t5_bready0", bus.BREADY, 0);
      chk("t5_awaddr0", bus.AWADDR, 0);
      chk("t5_wdata0", bus.WDATA, 0);
      chk("t5_level0", fifo_level, 0);
      chk("t5_cnt0", wr_done_cnt, 0);
      chk("t5_err0", err_timeout, 0);
      chk("t5_busy0", busy, 0);
      exp_aw.delete();
      exp_w.delete();
      tick(2);
      rst = 1'b0;
      slave(1'b1, 1'b1, 1'b1);
      tick();
      chk("t5_cmd_ready", bus.cmd_ready, 1);
      tick(6);
      chk("t5_busy_after", busy, 0);
      chk("t5_cnt_after", wr_done_cnt, 0);

      // 256 back-to-back writes at 2 cycles each wrap the done counter
      push(4'd0, 7'd0);
      c0 = cyc;
      for (int i = 1; i < 256; i++) push(4'(i), 7'(i * 3));
      wait_idle("t6_idle", 1000);
      chk("t6_cycles", cyc - c0, 513);
      chk("t6_cnt_wrap", wr_done_cnt, 0);
      chk("end_aw_queue", exp_aw.size(), 0);
      chk("end_w_queue", exp_w.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
